// File: rtl/bypass_network.sv
// EX operand bypass network: registered forward selects computed from early
// source addresses, priority operand mux, and a countdown scoreboard that
// raises a RAW stall while long-latency producers are still in flight.
module bypass_network #(
    parameter int XLEN       = 32,
    parameter int NUM_SRC    = 3,
    parameter int NUM_FWD    = 3,
    parameter int LONG_SLOTS = 4,
    parameter int LAT_W      = 5
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_stall,
    input  logic                        i_flush,
    input  logic [NUM_SRC*5-1:0]        i_src_early_addr,
    input  logic [NUM_SRC*XLEN-1:0]     i_src_rf_data,
    input  logic [NUM_SRC-1:0]          i_src_is_x0,
    input  logic [NUM_FWD-1:0]          i_pre_valid,
    input  logic [NUM_FWD*5-1:0]        i_pre_rd,
    input  logic [NUM_FWD*XLEN-1:0]     i_fwd_data,
    input  logic                        i_long_issue,
    input  logic [4:0]                  i_long_rd,
    input  logic [LAT_W-1:0]            i_long_lat,
    output logic [NUM_SRC*XLEN-1:0]     o_src_value,
    output logic [NUM_SRC*NUM_FWD-1:0]  o_fwd_hit,
    output logic                        o_raw_stall,
    output logic                        o_long_full
);

    // EX-resident source addresses, flattened for the scoreboard compare
    logic [NUM_SRC*5-1:0]    src_addr_flat;
    // Scoreboard state, flattened across slots
    logic [LONG_SLOTS-1:0]   sb_valid;
    logic [LONG_SLOTS*5-1:0] sb_rd_flat;
    logic [LONG_SLOTS-1:0]   alloc_vec;
    logic                    issue_ok;
    logic [LAT_W-1:0]        lat_eff;

    genvar gi;

    // ------------------------------------------------------------------
    // Per-operand select registration and operand mux
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [4:0]         early_addr;
            logic [NUM_FWD-1:0] hit_next;
            logic [NUM_FWD-1:0] hit_reg;
            logic [4:0]         src_addr_reg;
            logic [XLEN-1:0]    value;

            assign early_addr = i_src_early_addr[gi*5 +: 5];

            // Match every producer slot; x0 destinations never match
            always_comb begin
                hit_next = '0;
                for (int k = 0; k < NUM_FWD; k++) begin
                    hit_next[k] = i_pre_valid[k]
                                  && (i_pre_rd[k*5 +: 5] != 5'd0)
                                  && (i_pre_rd[k*5 +: 5] == early_addr);
                end
            end

            // Select and address registers: reset > flush > stall
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    hit_reg      <= '0;
                    src_addr_reg <= 5'd0;
                end else if (i_flush) begin
                    hit_reg      <= '0;
                    src_addr_reg <= 5'd0;
                end else if (!i_stall) begin
                    hit_reg      <= hit_next;
                    src_addr_reg <= early_addr;
                end
            end

            // Youngest matching producer wins (scan high to low, last write wins)
            always_comb begin
                value = i_src_is_x0[gi] ? '0 : i_src_rf_data[gi*XLEN +: XLEN];
                for (int k = NUM_FWD - 1; k >= 0; k--) begin
                    if (hit_reg[k]) begin
                        value = i_fwd_data[k*XLEN +: XLEN];
                    end
                end
            end

            assign o_src_value[gi*XLEN +: XLEN]       = value;
            assign o_fwd_hit[gi*NUM_FWD +: NUM_FWD]   = hit_reg;
            assign src_addr_flat[gi*5 +: 5]           = src_addr_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Long-latency scoreboard
    // ------------------------------------------------------------------
    assign o_long_full = &sb_valid;
    // Lowest slot that was free at the start of the cycle
    assign alloc_vec   = ~sb_valid & (sb_valid + LONG_SLOTS'(1));
    assign issue_ok    = i_long_issue && (i_long_rd != 5'd0) && !o_long_full;
    // A zero latency still needs one cycle of protection
    assign lat_eff     = (i_long_lat == '0) ? LAT_W'(1) : i_long_lat;

    generate
        for (gi = 0; gi < LONG_SLOTS; gi++) begin : g_slot
            logic             slot_valid_reg;
            logic [4:0]       slot_rd_reg;
            logic [LAT_W-1:0] slot_cnt_reg;

            // Count down independently of pipeline hold/flush; allocate when free
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    slot_valid_reg <= 1'b0;
                    slot_rd_reg    <= 5'd0;
                    slot_cnt_reg   <= '0;
                end else if (slot_valid_reg) begin
                    if (slot_cnt_reg <= LAT_W'(1)) begin
                        slot_valid_reg <= 1'b0;
                    end
                    slot_cnt_reg <= slot_cnt_reg - LAT_W'(1);
                end else if (issue_ok && alloc_vec[gi]) begin
                    slot_valid_reg <= 1'b1;
                    slot_rd_reg    <= i_long_rd;
                    slot_cnt_reg   <= lat_eff;
                end
            end

            assign sb_valid[gi]            = slot_valid_reg;
            assign sb_rd_flat[gi*5 +: 5]   = slot_rd_reg;
        end
    endgenerate

    // Stall while any EX source waits on a pending long-latency destination
    always_comb begin
        o_raw_stall = 1'b0;
        for (int j = 0; j < LONG_SLOTS; j++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (sb_valid[j]
                    && (src_addr_flat[s*5 +: 5] != 5'd0)
                    && (sb_rd_flat[j*5 +: 5] == src_addr_flat[s*5 +: 5])) begin
                    o_raw_stall = 1'b1;
                end
            end
        end
    end

`ifdef FORMAL
    // Producers must never issue into a full scoreboard
    always @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!(i_long_issue && o_long_full));
        end
    end
`endif

endmodule

// File: tb/tb_bypass_network.sv
// Scoreboard-driven bench for bypass_network: expectations are queued when
// stimulus is applied and compared once the DUT outputs have settled.
module tb_bypass_network;

    localparam int XLEN       = 32;
    localparam int NUM_SRC    = 3;
    localparam int NUM_FWD    = 3;
    localparam int LONG_SLOTS = 4;
    localparam int LAT_W      = 5;

    localparam int K_SRC  = 0;  // 0..2 : o_src_value[s]
    localparam int K_HIT  = 3;  // 3..5 : o_fwd_hit[s]
    localparam int K_RAW  = 6;
    localparam int K_FULL = 7;

    logic                        clk;
    logic                        rst;
    logic                        stall;
    logic                        flush;
    logic [NUM_SRC*5-1:0]        early_addr;
    logic [NUM_SRC*XLEN-1:0]     rf_data;
    logic [NUM_SRC-1:0]          is_x0;
    logic [NUM_FWD-1:0]          pre_valid;
    logic [NUM_FWD*5-1:0]        pre_rd;
    logic [NUM_FWD*XLEN-1:0]     fwd_data;
    logic                        long_issue;
    logic [4:0]                  long_rd;
    logic [LAT_W-1:0]            long_lat;
    logic [NUM_SRC*XLEN-1:0]     src_value;
    logic [NUM_SRC*NUM_FWD-1:0]  fwd_hit;
    logic                        raw_stall;
    logic                        long_full;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run;
    int   tests_failed;

    bypass_network #(
        .XLEN(XLEN), .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD),
        .LONG_SLOTS(LONG_SLOTS), .LAT_W(LAT_W)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_stall         (stall),
        .i_flush         (flush),
        .i_src_early_addr(early_addr),
        .i_src_rf_data   (rf_data),
        .i_src_is_x0     (is_x0),
        .i_pre_valid     (pre_valid),
        .i_pre_rd        (pre_rd),
        .i_fwd_data      (fwd_data),
        .i_long_issue    (long_issue),
        .i_long_rd       (long_rd),
        .i_long_lat      (long_lat),
        .o_src_value     (src_value),
        .o_fwd_hit       (fwd_hit),
        .o_raw_stall     (raw_stall),
        .o_long_full     (long_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s got=%h", tag, got);
        end
    endtask

    function automatic logic [31:0] observe(input int kind);
        logic [31:0] v;
        v = '0;
        if (kind >= K_SRC && kind < K_SRC + NUM_SRC)
            v = src_value[(kind - K_SRC)*XLEN +: XLEN];
        else if (kind >= K_HIT && kind < K_HIT + NUM_SRC)
            v = {{(32-NUM_FWD){1'b0}}, fwd_hit[(kind - K_HIT)*NUM_FWD +: NUM_FWD]};
        else if (kind == K_RAW)
            v = {31'd0, raw_stall};
        else if (kind == K_FULL)
            v = {31'd0, long_full};
        return v;
    endfunction

    task automatic expect_out(input string tag, input int kind, input logic [31:0] exp);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = exp;
        exp_q.push_back(e);
    endtask

    // Let combinational outputs settle, then compare everything pending
    task automatic drain();
        exp_t e;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val(e.tag, observe(e.kind), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        early_addr = '0; rf_data = '0; is_x0 = '0;
        pre_valid = '0; pre_rd = '0; fwd_data = '0;
        long_issue = 1'b0; long_rd = '0; long_lat = '0;
        repeat (2) tick();
        rst = 1'b0;

        // ---- Reset state and x0 masking ----
        rf_data[0*XLEN +: XLEN] = 32'h1234;
        rf_data[1*XLEN +: XLEN] = 32'h1111;
        rf_data[2*XLEN +: XLEN] = 32'h2222;
        is_x0 = 3'b001;
        expect_out("rst_src0_x0", K_SRC + 0, 32'h0);
        expect_out("rst_src1",    K_SRC + 1, 32'h1111);
        expect_out("rst_src2",    K_SRC + 2, 32'h2222);
        expect_out("rst_hit0",    K_HIT + 0, 32'h0);
        expect_out("rst_hit1",    K_HIT + 1, 32'h0);
        expect_out("rst_hit2",    K_HIT + 2, 32'h0);
        expect_out("rst_raw",     K_RAW,     32'h0);
        expect_out("rst_full",    K_FULL,    32'h0);
        drain();

        // ---- Forward priority; rd=0 producer never matches x0 source ----
        pre_valid = 3'b111;
        pre_rd    = {5'd0, 5'd5, 5'd5};
        early_addr = {5'd0, 5'd5, 5'd6};
        tick();
        fwd_data = {32'hCCCC, 32'hBBBB, 32'hAAAA};
        is_x0    = 3'b100;
        expect_out("prio_src1",  K_SRC + 1, 32'hAAAA);
        expect_out("prio_hit1",  K_HIT + 1, 32'h3);
        expect_out("prio_hit0",  K_HIT + 0, 32'h0);
        expect_out("prio_src0",  K_SRC + 0, 32'h1234);
        expect_out("x0_hit2",    K_HIT + 2, 32'h0);
        expect_out("x0_src2",    K_SRC + 2, 32'h0);
        drain();

        // ---- Stall holds selects while producer info changes ----
        stall     = 1'b1;
        pre_valid = 3'b011;
        pre_rd    = {5'd0, 5'd7, 5'd7};
        early_addr = {5'd0, 5'd7, 5'd6};
        for (int i = 0; i < 3; i++) begin
            tick();
            fwd_data[0 +: XLEN] = 32'hD000 + 32'(i);
            expect_out($sformatf("stall_src1_c%0d", i), K_SRC + 1, 32'hD000 + 32'(i));
            expect_out($sformatf("stall_hit1_c%0d", i), K_HIT + 1, 32'h3);
            drain();
        end
        // Flush wins over a simultaneous stall
        flush = 1'b1;
        tick();
        expect_out("flush_hit1", K_HIT + 1, 32'h0);
        expect_out("flush_src1", K_SRC + 1, 32'h1111);
        expect_out("flush_src0", K_SRC + 0, 32'h1234);
        drain();
        flush = 1'b0; stall = 1'b0; pre_valid = '0;

        // ---- Long op rd=x9 lat=4: stall exactly 4 cycles, ignores i_stall ----
        early_addr = {5'd0, 5'd0, 5'd9};
        long_issue = 1'b1; long_rd = 5'd9; long_lat = 5'd4;
        tick();
        long_issue = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            expect_out($sformatf("lat4_raw_c%0d", c), K_RAW, (c <= 4) ? 32'h1 : 32'h0);
            drain();
            stall = (c == 2 || c == 3);
            tick();
        end
        stall = 1'b0;

        // ---- Latency 0 behaves as 1 ----
        long_issue = 1'b1; long_rd = 5'd9; long_lat = 5'd0;
        tick();
        long_issue = 1'b0;
        expect_out("lat0_raw_c1", K_RAW, 32'h1);
        drain();
        tick();
        expect_out("lat0_raw_c2", K_RAW, 32'h0);
        drain();
        early_addr = '0;

        // ---- Fill scoreboard, drop while full, no same-cycle reuse ----
        for (int i = 0; i < LONG_SLOTS; i++) begin
            long_issue = 1'b1; long_rd = 5'(i + 1); long_lat = 5'd6;
            tick();
            expect_out($sformatf("fill_full_%0d", i), K_FULL, (i == LONG_SLOTS - 1) ? 32'h1 : 32'h0);
            drain();
        end
        long_rd = 5'd5; early_addr = {5'd0, 5'd0, 5'd5};
        tick();
        expect_out("drop_raw",  K_RAW,  32'h0);
        expect_out("drop_full", K_FULL, 32'h1);
        drain();
        long_issue = 1'b0;
        tick();
        expect_out("pre_free_full", K_FULL, 32'h1);
        drain();
        long_issue = 1'b1; long_rd = 5'd6; early_addr = {5'd0, 5'd0, 5'd6};
        tick();
        expect_out("reuse_same_raw",  K_RAW,  32'h0);
        expect_out("reuse_same_full", K_FULL, 32'h0);
        drain();
        tick();
        long_issue = 1'b0;
        expect_out("reuse_next_raw",  K_RAW,  32'h1);
        expect_out("reuse_next_full", K_FULL, 32'h0);
        drain();

        // Clean up via reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_out("mid_rst_raw",  K_RAW,  32'h0);
        expect_out("mid_rst_full", K_FULL, 32'h0);
        drain();

        // ---- Duplicate rd x3: lat 2 then lat 5 -> 6 stall cycles ----
        early_addr = {5'd0, 5'd0, 5'd3};
        long_issue = 1'b1; long_rd = 5'd3; long_lat = 5'd2;
        tick();
        long_lat = 5'd5;
        for (int c = 1; c <= 7; c++) begin
            expect_out($sformatf("dup_raw_c%0d", c), K_RAW, (c <= 6) ? 32'h1 : 32'h0);
            drain();
            tick();
            long_issue = 1'b0;
        end

        // ---- Same pair, reset in cycle 3 ----
        long_issue = 1'b1; long_rd = 5'd3; long_lat = 5'd2;
        tick();
        long_lat = 5'd5;
        tick();
        long_issue = 1'b0;
        expect_out("dup_rst_raw_c2", K_RAW, 32'h1);
        drain();
        tick();
        expect_out("dup_rst_raw_c3", K_RAW, 32'h1);
        drain();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_out("dup_rst_raw_after", K_RAW,  32'h0);
        expect_out("dup_rst_full",      K_FULL, 32'h0);
        drain();
        tick();
        expect_out("dup_rst_slots_free", K_RAW, 32'h0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
